// File: rtl/saturn_bus_ctrl_pkg.sv
// Shared bus command codes and sizing for the Saturn bus sequencer.
// Imported by saturn_bus_ctrl and saturn_bus_addr_ser.
package saturn_bus_ctrl_pkg;

    localparam int SATURN_ADDR_W   = 20;
    localparam int SATURN_MAX_XFER = 16;

    typedef enum logic [3:0] {
        CMD_NOP         = 4'h0,
        CMD_PC_READ     = 4'h1,
        CMD_DP_READ     = 4'h2,
        CMD_PC_WRITE    = 4'h3,
        CMD_DP_WRITE    = 4'h4,
        CMD_LOAD_PC     = 4'h5,
        CMD_LOAD_DP     = 4'h6,
        CMD_CONFIGURE   = 4'h7,
        CMD_UNCONFIGURE = 4'h8,
        CMD_RESET       = 4'hF
    } bus_cmd_t;

endpackage

// File: rtl/saturn_bus_addr_ser.sv
// Address serializer: loads a full address, then presents it
// one nibble at a time, LSB nibble first, flagging the final nibble.
module saturn_bus_addr_ser
    import saturn_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W = SATURN_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_step,
    output logic [3:0]        o_nibble,
    output logic              o_last
);

    localparam int NIBS = ADDR_W / 4;

    logic [ADDR_W-1:0] sh_q;
    logic [2:0]        cnt_q;

    // Shift register and nibble index; stepping stops on the last nibble.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (i_load) begin
            sh_q  <= i_addr;
            cnt_q <= '0;
        end else if (i_step && !o_last) begin
            sh_q  <= sh_q >> 4;
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign o_nibble = sh_q[3:0];
    assign o_last   = (cnt_q == 3'(NIBS - 1));

endmodule

// File: rtl/saturn_bus_ctrl.sv
// Saturn nibble-bus sequencer: instruction fetch, PC reloads and DP transfers.
// Optional bus-error trap enabled by defining SATURN_BUS_ERRCHK_EN.
module saturn_bus_ctrl
    import saturn_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W   = SATURN_ADDR_W,
    parameter int MAX_XFER = SATURN_MAX_XFER
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_en_bus_send,
    input  logic                         i_en_bus_recv,
    input  logic                         i_fetch_en,
    input  logic                         i_pc_load,
    input  logic [ADDR_W-1:0]            i_pc_addr,
    input  logic                         i_data_req,
    input  logic                         i_data_write,
    input  logic [ADDR_W-1:0]            i_data_addr,
    input  logic [$clog2(MAX_XFER)-1:0]  i_data_len,
    input  logic [3:0]                   i_data_wnib,
    input  logic [3:0]                   i_bus_nibble_in,
    input  logic                         i_bus_error,
    output logic                         o_bus_strobe,
    output logic [3:0]                   o_bus_cmd,
    output logic [3:0]                   o_bus_nibble_out,
    output logic [3:0]                   o_nibble,
    output logic                         o_nibble_valid,
    output logic [3:0]                   o_data_nibble,
    output logic                         o_data_valid,
    output logic                         o_data_ready,
    output logic                         o_data_done,
    output logic                         o_stalled,
    output logic                         o_bus_error
);

    localparam int LEN_W = $clog2(MAX_XFER);

    typedef enum logic [2:0] {
        S_LOAD_PC = 3'd0,
        S_PC_ADDR = 3'd1,
        S_FETCH   = 3'd2,
        S_LOAD_DP = 3'd3,
        S_DP_ADDR = 3'd4,
        S_DP_XFER = 3'd5
`ifdef SATURN_BUS_ERRCHK_EN
        ,
        S_ERROR   = 3'd6
`endif
    } state_t;

    state_t state_q, state_d;

    logic              pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic              dp_write_q;
    logic [ADDR_W-1:0] dp_addr_q;
    logic [LEN_W-1:0]  xfer_q;
    logic              rd_pc_q;
    logic              rd_dp_q;
    logic              last_q;
    logic              err_hit;

    bus_cmd_t          iss_cmd;
    logic [3:0]        iss_nib;
    logic              iss_stb;
    logic              restart;
    logic              consume;
    logic              accept;
    logic              xfer_last;

    logic              ser_load;
    logic              ser_step;
    logic [ADDR_W-1:0] ser_addr;
    logic [3:0]        ser_nib;
    logic              ser_last;

    saturn_bus_addr_ser #(
        .ADDR_W (ADDR_W)
    ) u_addr_ser (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_load   (i_en_bus_send & ser_load),
        .i_addr   (ser_addr),
        .i_step   (i_en_bus_send & ser_step),
        .o_nibble (ser_nib),
        .o_last   (ser_last)
    );

`ifdef SATURN_BUS_ERRCHK_EN
    logic err_q;

    assign err_hit     = i_en_bus_recv & i_bus_error;
    assign o_bus_error = err_q;

    // Sticky bus error flag, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_q <= 1'b0;
        end else if (err_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_bus_error;

    assign err_hit          = 1'b0;
    assign unused_bus_error = i_bus_error;
    assign o_bus_error      = 1'b0;
`endif

    // State register; an error trap overrides the normal send-slot advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_LOAD_PC;
`ifdef SATURN_BUS_ERRCHK_EN
        end else if (err_hit) begin
            state_q <= S_ERROR;
`endif
        end else if (i_en_bus_send) begin
            state_q <= state_d;
        end
    end

    // Next state and the command to issue at the coming send slot.
    always_comb begin
        state_d   = state_q;
        iss_cmd   = CMD_NOP;
        iss_nib   = 4'h0;
        iss_stb   = 1'b0;
        ser_load  = 1'b0;
        ser_step  = 1'b0;
        ser_addr  = pend_addr_q;
        consume   = 1'b0;
        accept    = 1'b0;
        xfer_last = 1'b0;
        restart   = pend_q && (state_q == S_LOAD_PC ||
                               state_q == S_PC_ADDR ||
                               state_q == S_FETCH);
        if (restart) begin
            iss_cmd  = CMD_LOAD_PC;
            iss_stb  = 1'b1;
            ser_load = 1'b1;
            consume  = 1'b1;
            state_d  = S_PC_ADDR;
        end else begin
            unique case (state_q)
                S_LOAD_PC: begin
                    iss_cmd  = CMD_LOAD_PC;
                    iss_stb  = 1'b1;
                    ser_load = 1'b1;
                    state_d  = S_PC_ADDR;
                end
                S_PC_ADDR: begin
                    iss_cmd  = CMD_LOAD_PC;
                    iss_nib  = ser_nib;
                    iss_stb  = 1'b1;
                    ser_step = 1'b1;
                    if (ser_last) begin
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (i_data_req) begin
                        accept   = 1'b1;
                        iss_cmd  = CMD_LOAD_DP;
                        iss_stb  = 1'b1;
                        ser_load = 1'b1;
                        ser_addr = i_data_addr;
                        state_d  = S_DP_ADDR;
                    end else if (i_fetch_en) begin
                        iss_cmd = CMD_PC_READ;
                        iss_stb = 1'b1;
                    end
                end
                // Not entered: LOAD_DP goes out in the accepting slot.
                S_LOAD_DP: begin
                    iss_cmd  = CMD_LOAD_DP;
                    iss_stb  = 1'b1;
                    ser_load = 1'b1;
                    ser_addr = dp_addr_q;
                    state_d  = S_DP_ADDR;
                end
                S_DP_ADDR: begin
                    iss_cmd  = CMD_LOAD_DP;
                    iss_nib  = ser_nib;
                    iss_stb  = 1'b1;
                    ser_step = 1'b1;
                    if (ser_last) begin
                        state_d = S_DP_XFER;
                    end
                end
                S_DP_XFER: begin
                    iss_cmd = dp_write_q ? CMD_DP_WRITE : CMD_DP_READ;
                    iss_nib = dp_write_q ? i_data_wnib : 4'h0;
                    iss_stb = 1'b1;
                    if (xfer_q == '0) begin
                        xfer_last = 1'b1;
                        state_d   = pend_q ? S_LOAD_PC : S_FETCH;
                    end
                end
`ifdef SATURN_BUS_ERRCHK_EN
                S_ERROR: begin
                    state_d = S_ERROR;
                end
`endif
                default: begin
                    state_d = S_LOAD_PC;
                end
            endcase
        end
    end

    // Pending jump: latched on any cycle, newest pulse wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else if (i_pc_load) begin
            pend_q      <= 1'b1;
            pend_addr_q <= i_pc_addr;
        end else if (i_en_bus_send && consume) begin
            pend_q      <= 1'b0;
        end
    end

    // Transfer descriptor latch and remaining-nibble countdown.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            xfer_q     <= '0;
        end else if (i_en_bus_send) begin
            if (accept) begin
                dp_write_q <= i_data_write;
                dp_addr_q  <= i_data_addr;
                xfer_q     <= i_data_len;
            end else if (state_q == S_DP_XFER && xfer_q != '0) begin
                xfer_q <= xfer_q - 1'b1;
            end
        end
    end

    // Command register: strobe lasts the cycle after each send slot.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_bus_strobe     <= 1'b0;
            o_bus_cmd        <= CMD_NOP;
            o_bus_nibble_out <= 4'h0;
        end else begin
            o_bus_strobe <= i_en_bus_send & iss_stb;
            if (i_en_bus_send) begin
                o_bus_cmd        <= iss_cmd;
                o_bus_nibble_out <= iss_nib;
            end
        end
    end

    // Read-data capture on the receive slot following a read command.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_pc_q        <= 1'b0;
            rd_dp_q        <= 1'b0;
            last_q         <= 1'b0;
            o_nibble       <= 4'h0;
            o_nibble_valid <= 1'b0;
            o_data_nibble  <= 4'h0;
            o_data_valid   <= 1'b0;
            o_data_done    <= 1'b0;
        end else begin
            o_nibble_valid <= 1'b0;
            o_data_valid   <= 1'b0;
            o_data_done    <= 1'b0;
            if (i_en_bus_recv) begin
                if (rd_pc_q) begin
                    o_nibble       <= i_bus_nibble_in;
                    o_nibble_valid <= 1'b1;
                end
                if (rd_dp_q) begin
                    o_data_nibble <= i_bus_nibble_in;
                    o_data_valid  <= 1'b1;
                end
                if (last_q) begin
                    o_data_done <= 1'b1;
                end
                rd_pc_q <= 1'b0;
                rd_dp_q <= 1'b0;
                last_q  <= 1'b0;
            end
            if (i_en_bus_send) begin
                rd_pc_q <= iss_stb && (iss_cmd == CMD_PC_READ);
                rd_dp_q <= iss_stb && (iss_cmd == CMD_DP_READ);
                last_q  <= xfer_last;
            end
            if (err_hit) begin
                rd_pc_q <= 1'b0;
                rd_dp_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    assign o_data_ready = (state_q == S_FETCH) && !pend_q;
    assign o_stalled    = !o_data_ready;

endmodule
